fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the ARM pipeline: owns the PC, issues instruction-memory requests, absorbs variable memory latency and drives the IF/ID register inputs.
- Sits directly upstream of the IF/ID register.
- Consumes branch redirects from the condition handler (EX) and stall/enable from the hazard unit.
- Replaces the loose PC mux, PC+4 adder and flush OR with one sequential block.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, PC/address width.
- NOP_WORD, 32'h0000_0000, word presented to IF/ID on flush or bubble.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- CLR  in  1  asynchronous active-high reset.
- pc_enable  in  1  hazard unit; 0 = stall, hold PC and IF/ID outputs.
- branch_taken  in  1  condition handler T_Addr; redirect this cycle.
- branch_target  in  ADDR_W  redirect address (ID adder result).
- imem_req  out  1  request valid to instruction RAM.
- imem_addr  out  ADDR_W  byte address, word-aligned (bits [1:0] = 0).
- imem_ready  in  1  RAM returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- inst_out  out  32  instruction to IF/ID.
- pc_out  out  ADDR_W  address of inst_out.
- pc_plus4_out  out  ADDR_W  pc_out + 4, used for BL link and the R15 read.
- inst_valid  out  1  inst_out is a real instruction, not a bubble.

Behaviour:
- Reset (CLR=1, async):
  - PC=RESET_PC; state=S_RST; imem_req=0.
  - inst_out=NOP_WORD, pc_out=0, pc_plus4_out=4, inst_valid=0.
  - The hold buffer is emptied.
- States:
  - S_RST: one cycle after CLR falls, then S_REQ.
  - S_REQ: imem_req=1, imem_addr=PC.
    - If imem_ready, capture the word and go to S_REQ at PC+4.
    - Otherwise go to S_WAIT.
  - S_WAIT: imem_req=1, address held; on imem_ready capture the word, go to S_REQ.
- Latency: 1 cycle when imem_ready is asserted in the request cycle. A captured word appears on inst_out at the next rising edge with inst_valid=1.
- Stall (pc_enable=0):
  - PC and outputs are held.
  - A word returning during the stall goes into a 1-entry hold buffer, and no new request issues while the buffer is full.
  - On release, the buffer drains to the outputs first.
  - The hold buffer never overflows: requests are gated while it is full.
- Branch (branch_taken=1):
  - PC <= branch_target at the edge. An in-flight or buffered word is squashed.
  - Outputs become NOP_WORD with inst_valid=0 for that cycle.
  - The next request goes to branch_target.
  - A branch has priority over a stall.
  - If a branch arrives in S_WAIT, the pending response is discarded when imem_ready arrives. The RAM is not cancelled mid-request.
- Simultaneous branch_taken and imem_ready: the returned word is squashed and the redirect wins.
- Misaligned branch_target: bits [1:0] are forced to 0.
- PC arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0.
- CLR asserted mid-request returns to the reset state immediately, ignoring imem_ready.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Enabled: adds three 32-bit saturating counters, fetched_cnt, squashed_cnt and stall_cnt, exposed as extra output ports, cleared by CLR.
  - fetched_cnt counts words delivered with inst_valid=1.
  - squashed_cnt counts words discarded by a redirect.
  - stall_cnt counts cycles with pc_enable=0.
- Disabled: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Package arm_pipe_pkg holds:
  - the fetch state enum (S_RST, S_REQ, S_WAIT);
  - the NOP_WORD default;
  - the RESET_PC default;
  - the word-align mask constant.
- Sub-module fetch_hold_buf: 1-entry buffer with valid flag, load, drain and flush. Instantiated once.

Test Plan:
- Straight-line fetch: reset, imem_ready tied to 1 → pc_out sequence 0,4,8,12 on consecutive cycles; inst_valid=1 from the second cycle after CLR falls.
- Slow memory: imem_ready asserted 3 cycles after each request → imem_addr held 3 cycles; inst_out updates once per response; PC advances by 4 each time.
- Stall with return: pc_enable=0 for 4 cycles while the word for 0x10 returns → outputs held at 0x0C; word for 0x10 buffered; no new imem_req. After release, pc_out=0x10 next cycle, then 0x14.
- Branch during wait: branch_taken=1 with target 0x40 in S_WAIT, then imem_ready → the stale word is never presented; next imem_addr=0x40; inst_valid=0 for one cycle.
- Branch plus stall plus ready in the same cycle: target 0x83 → PC=0x80; the returned word is squashed; inst_out=NOP_WORD.
- Async reset mid-wait: CLR pulsed between edges → outputs reset immediately; imem_req=0; first request after recovery is RESET_PC.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared constants for the ARM pipeline front end: fetch FSM
// encodings, reset/NOP defaults, the word-align mask and a counter helper.
package arm_pipe_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_RST  = 2'd0;
    localparam fetch_state_t S_REQ  = 2'd1;
    localparam fetch_state_t S_WAIT = 2'd2;

    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] value,
        input logic        en
    );
        if (en && value != 32'hFFFF_FFFF)
            return value + 32'd1;
        return value;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding slot for an instruction word that returns while
// the pipeline is stalled. Flush beats load, load beats drain.
module fetch_hold_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic              flush,
    input  logic [31:0]       load_word,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              valid,
    output logic [31:0]       word,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            word  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            word  <= load_word;
            pc    <= load_pc;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC ownership, instruction-memory handshake and IF/ID drive.
// Define FETCH_PERF_EN to add fetched/squashed/stall counters.
module fetch_stage
    import arm_pipe_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter logic [31:0]       NOP_WORD = NOP_WORD_DEF
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              pc_enable,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4_out,
    output logic              inst_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetched_cnt,
    output logic [31:0]       squashed_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'(~ALIGN_MASK);
    localparam logic [ADDR_W-1:0] FOUR  = ADDR_W'(4);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] req_addr;
    logic              discard;

    logic              buf_valid;
    logic [31:0]       buf_word;
    logic [ADDR_W-1:0] buf_pc;

    logic              accept;
    logic              squash;
    logic              capture;
    logic              buf_load;
    logic              buf_drain;

    // The RAM keeps its address until it answers, even across a redirect.
    assign imem_req  = (state == S_WAIT) ||
                       (state == S_REQ && !buf_valid);
    assign imem_addr = (state == S_WAIT) ? req_addr : pc;

    assign accept    = imem_req && imem_ready;
    assign squash    = branch_taken || (state == S_WAIT && discard);
    assign capture   = accept && !squash;
    assign buf_load  = capture && !pc_enable;
    assign buf_drain = pc_enable && !branch_taken && buf_valid;

    fetch_hold_buf #(
        .ADDR_W (ADDR_W)
    ) u_hold (
        .clk       (CLK),
        .rst       (CLR),
        .load      (buf_load),
        .drain     (buf_drain),
        .flush     (branch_taken),
        .load_word (imem_rdata),
        .load_pc   (imem_addr),
        .valid     (buf_valid),
        .word      (buf_word),
        .pc        (buf_pc)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_RST:   state_nxt = S_REQ;
            S_REQ:   if (imem_req && !imem_ready) state_nxt = S_WAIT;
            S_WAIT:  if (imem_ready) state_nxt = S_REQ;
            default: state_nxt = S_RST;
        endcase
    end

    always_comb begin
        pc_nxt = pc;
        if (branch_taken)
            pc_nxt = branch_target & AMASK;
        else if (capture)
            pc_nxt = pc + FOUR;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= S_RST;
            pc       <= RESET_PC & AMASK;
            req_addr <= '0;
            discard  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == S_REQ && imem_req && !imem_ready) begin
                req_addr <= pc;
                discard  <= branch_taken;
            end else if (state == S_WAIT) begin
                discard <= imem_ready ? 1'b0 : (discard | branch_taken);
            end
        end
    end

    // Redirect beats stall; a buffered word drains before any new fetch.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            inst_out     <= NOP_WORD;
            pc_out       <= '0;
            pc_plus4_out <= FOUR;
            inst_valid   <= 1'b0;
        end else if (branch_taken) begin
            inst_out   <= NOP_WORD;
            inst_valid <= 1'b0;
        end else if (!pc_enable) begin
            inst_valid <= inst_valid;
        end else if (buf_valid) begin
            inst_out     <= buf_word;
            pc_out       <= buf_pc;
            pc_plus4_out <= buf_pc + FOUR;
            inst_valid   <= 1'b1;
        end else if (capture) begin
            inst_out     <= imem_rdata;
            pc_out       <= imem_addr;
            pc_plus4_out <= imem_addr + FOUR;
            inst_valid   <= 1'b1;
        end else begin
            inst_out   <= NOP_WORD;
            inst_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    logic delivered;
    logic dropped;

    assign delivered = pc_enable && !branch_taken &&
                       (buf_valid || capture);
    assign dropped   = (accept && squash) ||
                       (branch_taken && buf_valid);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            fetched_cnt  <= '0;
            squashed_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            fetched_cnt  <= sat_inc(fetched_cnt, delivered);
            squashed_cnt <= sat_inc(squashed_cnt, dropped);
            stall_cnt    <= sat_inc(stall_cnt, !pc_enable);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, all
// checked against a transaction-level model of the fetch unit.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        pc_enable = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        inst_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] fetched_cnt;
    logic [31:0] squashed_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .CLK           (CLK),
        .CLR           (CLR),
        .pc_enable     (pc_enable),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .pc_plus4_out  (pc_plus4_out),
        .inst_valid    (inst_valid)
`ifdef FETCH_PERF_EN
        ,
        .fetched_cnt   (fetched_cnt),
        .squashed_cnt  (squashed_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model: next fetch address, one outstanding RAM request
    // (possibly stale after a redirect), a stash queue, and IF/ID outputs.
    logic        m_started;
    logic        m_busy;
    logic        m_stale;
    logic [31:0] m_pc;
    logic [31:0] m_busy_addr;
    logic [31:0] m_inst;
    logic [31:0] m_pco;
    logic [31:0] m_pcp4;
    logic        m_valid;
    logic [63:0] m_hold[$];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    function automatic logic exp_req();
        return m_started && (m_busy || m_hold.size() == 0);
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_busy ? m_busy_addr : m_pc;
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_busy    = 1'b0;
        m_stale   = 1'b0;
        m_pc      = 32'h0;
        m_inst    = 32'h0;
        m_pco     = 32'h0;
        m_pcp4    = 32'h4;
        m_valid   = 1'b0;
        m_hold.delete();
    endtask

    task automatic deliver(input logic [31:0] a, input logic [31:0] w);
        m_inst  = w;
        m_pco   = a;
        m_pcp4  = a + 32'd4;
        m_valid = 1'b1;
    endtask

    task automatic bubble();
        m_inst  = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic br,
                              input logic [31:0] tgt, input logic rdy,
                              input logic [31:0] w);
        logic        req;
        logic [31:0] a;
        logic        got;
        logic        good;
        logic [63:0] e;
        req  = exp_req();
        a    = exp_addr();
        got  = req && rdy;
        good = got && !(br || (m_busy && m_stale));
        if (br) begin
            m_hold.delete();
            bubble();
        end else if (!en) begin
            if (good) m_hold.push_back({a, w});
        end else if (m_hold.size() != 0) begin
            e = m_hold.pop_front();
            deliver(e[63:32], e[31:0]);
        end else if (good) begin
            deliver(a, w);
        end else begin
            bubble();
        end
        if (req && !rdy) begin
            m_stale     = m_busy ? (m_stale || br) : br;
            m_busy      = 1'b1;
            m_busy_addr = a;
        end else if (got) begin
            m_busy  = 1'b0;
            m_stale = 1'b0;
        end
        if (br) m_pc = {tgt[31:2], 2'b00};
        else if (good) m_pc = m_pc + 32'd4;
        m_started = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; one full clock cycle of stimulus.
    task automatic step(input logic en, input logic br,
                        input logic [31:0] tgt, input logic rdy);
        logic [31:0] w;
        pc_enable     = en;
        branch_taken  = br;
        branch_target = tgt;
        imem_ready    = rdy;
        w             = memword(exp_addr());
        imem_rdata    = rdy ? w : $urandom;
        #1;
        chk("imem_req", 32'(imem_req), 32'(exp_req()));
        if (exp_req()) chk("imem_addr", imem_addr, exp_addr());
        @(posedge CLK);
        model_edge(en, br, tgt, rdy, w);
        #1;
        chk("inst_valid", 32'(inst_valid), 32'(m_valid));
        chk("inst_out", inst_out, m_inst);
        chk("pc_out", pc_out, m_pco);
        chk("pc_plus4_out", pc_plus4_out, m_pcp4);
        @(negedge CLK);
    endtask

    // CLR pulsed between edges; leaves time before the next rising edge.
    task automatic pulse_reset();
        pc_enable    = 1'b1;
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        #1 CLR = 1'b1;
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst", inst_out, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_pc4", pc_plus4_out, 32'h4);
        CLR = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(negedge CLK);
        pulse_reset();

        // Straight-line fetch with a zero-wait memory.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("sl_first_valid", 32'(inst_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            chk("sl_pc", pc_out, 32'(i * 4));
            chk("sl_valid", 32'(inst_valid), 32'h1);
        end

        // Stall while the word for 0x10 returns.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_hold", pc_out, 32'h0C);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("stall_noreq", 32'(imem_req), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_hold2", pc_out, 32'h0C);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("release_pc", pc_out, 32'h10);
        chk("release_inst", inst_out, memword(32'h10));
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("release_next", pc_out, 32'h14);

        // Redirect while a request is outstanding.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h40, 1'b0);
        chk("brw_bubble", 32'(inst_valid), 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("brw_stale_valid", 32'(inst_valid), 32'h0);
        chk("brw_stale_inst", inst_out, 32'h0);
        chk("brw_addr", imem_addr, 32'h40);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("brw_pc", pc_out, 32'h40);

        // Redirect, stall and ready together, misaligned target.
        step(1'b0, 1'b1, 32'h83, 1'b1);
        chk("bsr_inst", inst_out, 32'h0);
        chk("bsr_valid", 32'(inst_valid), 32'h0);
        chk("bsr_addr", imem_addr, 32'h80);

        // Slow memory: answer on the third cycle of each request.
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                chk("slow_addr", imem_addr, 32'(32'h80 + 4 * k));
                step(1'b1, 1'b0, 32'h0, j == 2);
            end
            chk("slow_pc", pc_out, 32'(32'h80 + 4 * k));
            chk("slow_valid", 32'(inst_valid), 32'h1);
        end

        // Address wrap at the top of the space.
        step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("wrap_next", pc_out, 32'h0);

        // Asynchronous reset in the middle of a wait.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        pulse_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("rec_req", 32'(imem_req), 32'h1);
        chk("rec_addr", imem_addr, 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) pulse_reset();
            step($urandom_range(99) < 75, $urandom_range(99) < 8,
                 $urandom, $urandom_range(99) < 55);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
